// File: rtl/mont_pkg.sv
// Shared types for the Montgomery exponentiation datapath (mont_exp_seq, mont_mul).
package mont_pkg;
  typedef logic [31:0] data_word_t;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_SCAN, ST_SQR_ST, ST_SQR_WT, ST_MUL_ST, ST_MUL_WT, ST_FIN
  } exp_state_e;

  localparam int WORD_SHIFT = 2;

  // Byte address of 32-bit word idx relative to base.
  function automatic data_word_t addr_offset(input data_word_t base, input data_word_t idx);
    return base + (idx << WORD_SHIFT);
  endfunction
endpackage

// File: rtl/mont_exp_seq_exp_bit_buf.sv
// Exponent storage: written one 32-bit word at a time, read one bit at a time.
module exp_bit_buf import mont_pkg::*; #(
  parameter int WORDS = 8,
  localparam int NBITS = WORDS * 32,
  localparam int BW    = $clog2(NBITS),
  localparam int WAW   = $clog2(WORDS)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we,
  input  logic [WAW-1:0] waddr,
  input  data_word_t     wdata,
  input  logic [BW-1:0]  bit_idx,
  output logic           bit_val
);
  logic [WORDS-1:0][31:0] mem;
  logic [NBITS-1:0]       flat;

  always_ff @(posedge clk) begin
    if (rst)     mem <= '0;
    else if (we) mem[waddr] <= wdata;
  end

  assign flat    = mem;
  assign bit_val = flat[bit_idx];
endmodule

// File: rtl/mont_exp_seq.sv
// Left-to-right square-and-multiply sequencer driving mont_mul; the accumulator
// lives in memory at res_addr and is updated in place.
module mont_exp_seq import mont_pkg::*; #(
  parameter int WORDS          = 8,
  parameter bit SKIP_LEAD_ZERO = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  data_word_t base_addr,
  input  data_word_t exp_addr,
  input  data_word_t n_addr,
  input  data_word_t res_addr,
  output logic       lsu_ren,
  output data_word_t lsu_addr,
  input  logic       lsu_done,
  input  data_word_t lsu_rdata,
  output logic       mm_start,
  output data_word_t mm_a_addr,
  output data_word_t mm_b_addr,
  output data_word_t mm_n_addr,
  output data_word_t mm_res_addr,
  input  logic       mm_done,
  output logic       busy,
  output logic       done
);
  localparam int NBITS = WORDS * 32;
  localparam int BIW   = $clog2(NBITS) + 1;
  localparam int WIW   = $clog2(WORDS) + 1;
  localparam logic [BIW-1:0] TOP_BIT = BIW'(NBITS - 1);
  localparam logic [WIW-1:0] LAST_W  = WIW'(WORDS - 1);

  exp_state_e     state, state_d;
  logic [BIW-1:0] bidx;
  logic [WIW-1:0] widx;
  logic           st_cnt;
  data_word_t     base_q, exp_q, n_q, res_q;
  logic           cur_bit, last_bit, buf_we;

  assign buf_we   = (state == ST_FETCH) && lsu_done;
  assign last_bit = (bidx == '0);

  exp_bit_buf #(.WORDS(WORDS)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .we      (buf_we),
    .waddr   (widx[WIW-2:0]),
    .wdata   (lsu_rdata),
    .bit_idx (bidx[BIW-2:0]),
    .bit_val (cur_bit)
  );

  always_comb begin
    state_d  = state;
    lsu_ren  = 1'b0;
    mm_start = 1'b0;
    done     = 1'b0;
    busy     = (state != ST_IDLE);
    unique case (state)
      ST_IDLE:  if (start) state_d = ST_FETCH;
      ST_FETCH: begin
        lsu_ren = 1'b1;
        if (lsu_done && widx == LAST_W) state_d = SKIP_LEAD_ZERO ? ST_SCAN : ST_SQR_ST;
      end
      // Leading one goes straight to a multiply: acc starts at 1, so its square is a no-op.
      ST_SCAN: begin
        if (cur_bit)       state_d = ST_MUL_ST;
        else if (last_bit) state_d = ST_FIN;
      end
      ST_SQR_ST: begin
        mm_start = 1'b1;
        if (st_cnt) state_d = ST_SQR_WT;
      end
      ST_MUL_ST: begin
        mm_start = 1'b1;
        if (st_cnt) state_d = ST_MUL_WT;
      end
      ST_SQR_WT: if (mm_done) state_d = cur_bit ? ST_MUL_ST : (last_bit ? ST_FIN : ST_SQR_ST);
      ST_MUL_WT: if (mm_done) state_d = last_bit ? ST_FIN : ST_SQR_ST;
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      bidx   <= '0;
      widx   <= '0;
      st_cnt <= 1'b0;
      base_q <= '0;
      exp_q  <= '0;
      n_q    <= '0;
      res_q  <= '0;
    end else begin
      state <= state_d;
      unique case (state)
        ST_IDLE: if (start) begin
          base_q <= base_addr;
          exp_q  <= exp_addr;
          n_q    <= n_addr;
          res_q  <= res_addr;
          bidx   <= TOP_BIT;
          widx   <= '0;
        end
        ST_FETCH:  if (lsu_done) widx <= widx + 1'b1;
        ST_SCAN:   if (!cur_bit && !last_bit) bidx <= bidx - 1'b1;
        // mont_mul takes A/B on the first start cycle and N/res on the second.
        ST_SQR_ST, ST_MUL_ST: st_cnt <= ~st_cnt;
        ST_SQR_WT: if (mm_done && !cur_bit && !last_bit) bidx <= bidx - 1'b1;
        ST_MUL_WT: if (mm_done && !last_bit) bidx <= bidx - 1'b1;
        default: ;
      endcase
    end
  end

  assign lsu_addr    = addr_offset(exp_q, data_word_t'(widx));
  assign mm_a_addr   = res_q;
  assign mm_b_addr   = (state == ST_MUL_ST || state == ST_MUL_WT) ? base_q : res_q;
  assign mm_n_addr   = n_q;
  assign mm_res_addr = res_q;
endmodule
